// File: rtl/lstm_gate_mac.sv
// Four-gate LSTM pre-activation engine: streams [x_t ; h_t-1] against per-gate weights,
// rounds and saturates each Q.FRAC dot product, and holds the result under valid/ready.
module lstm_gate_mac #(
   parameter int XLEN    = 16,
   parameter int FRAC    = 8,
   parameter int VEC_LEN = 32,
   parameter int ACC_W   = 40
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [XLEN-1:0] b_i,
   input  logic [XLEN-1:0] b_c,
   input  logic [XLEN-1:0] b_f,
   input  logic [XLEN-1:0] b_o,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] x_data,
   input  logic [XLEN-1:0] w_i,
   input  logic [XLEN-1:0] w_c,
   input  logic [XLEN-1:0] w_f,
   input  logic [XLEN-1:0] w_o,
   output logic [XLEN-1:0] gate_i,
   output logic [XLEN-1:0] gate_c,
   output logic [XLEN-1:0] gate_f,
   output logic [XLEN-1:0] gate_o,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [1:0]      status_out
);

   localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   // Rounding constant and saturation bounds expressed at accumulator width.
   localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (FRAC - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-XLEN+1){1'b0}}, {(XLEN-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-XLEN+1){1'b1}}, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] OUT_MAX = {1'b0, {(XLEN-1){1'b1}}};
   localparam logic [XLEN-1:0] OUT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             load_bias, beat_ok;

   logic [XLEN-1:0] bias_a [4];
   logic [XLEN-1:0] w_a    [4];
   logic [XLEN-1:0] gate_a [4];

   assign bias_a[0] = b_i;
   assign bias_a[1] = b_c;
   assign bias_a[2] = b_f;
   assign bias_a[3] = b_o;
   assign w_a[0]    = w_i;
   assign w_a[1]    = w_c;
   assign w_a[2]    = w_f;
   assign w_a[3]    = w_o;

   assign load_bias = (state_q == S_IDLE) && start;
   assign beat_ok   = (state_q == S_ACCUM) && in_valid;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ACCUM;
               cnt_d   = '0;
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               if (cnt_q == LAST_BEAT) begin
                  state_d = S_ROUND;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_ROUND: begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
         end
         S_HOLD: begin
            // A start arriving with the handshake is dropped: IDLE is entered only after this edge.
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_gate
         logic signed [2*XLEN-1:0] w_ext, x_ext, prod;
         logic signed [ACC_W-1:0]  acc_q, acc_d, sum, rnd;
         logic [XLEN-1:0]          gate_q, gate_d;

         always_comb begin
            w_ext  = {{XLEN{w_a[gi][XLEN-1]}}, w_a[gi]};
            x_ext  = {{XLEN{x_data[XLEN-1]}}, x_data};
            prod   = w_ext * x_ext;
            sum    = acc_q + HALF;
            rnd    = sum >>> FRAC;
            acc_d  = acc_q;
            gate_d = gate_q;
            if (load_bias) begin
               acc_d = {{(ACC_W-XLEN){bias_a[gi][XLEN-1]}}, bias_a[gi]} << FRAC;
            end else if (beat_ok) begin
               acc_d = acc_q + {{(ACC_W-2*XLEN){prod[2*XLEN-1]}}, prod};
            end
            if (state_q == S_ROUND) begin
               if (rnd > SAT_MAX) begin
                  gate_d = OUT_MAX;
               end else if (rnd < SAT_MIN) begin
                  gate_d = OUT_MIN;
               end else begin
                  gate_d = rnd[XLEN-1:0];
               end
            end
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               acc_q  <= '0;
               gate_q <= '0;
            end else begin
               acc_q  <= acc_d;
               gate_q <= gate_d;
            end
         end

         assign gate_a[gi] = gate_q;
      end
   endgenerate

   assign gate_i     = gate_a[0];
   assign gate_c     = gate_a[1];
   assign gate_f     = gate_a[2];
   assign gate_o     = gate_a[3];
   assign in_ready   = (state_q == S_ACCUM);
   assign out_valid  = out_valid_q;
   assign status_out = state_q;

endmodule

// File: doc/lstm_gate_mac.md
Name: lstm_gate_mac

Overview:
Per-neuron gate pre-activation engine that sits directly upstream of the LSTM neuron node. It computes four pre-activations, one per gate (i, c~, f, o), as a dot product over a concatenated vector [x_t ; h_t-1] plus a bias. The vector is streamed one element per beat together with the four matching weights. Each accumulated sum is rounded, saturated to LSTM_XLEN and held under a valid/ready handshake until the neuron's gate input packets take it.

Parameters:
XLEN, 16, data width of vector elements, weights, biases and outputs (signed two's complement, equals LSTM_XLEN)
FRAC, 8, fractional bits of every XLEN-wide operand
VEC_LEN, 32, beats per dot product (input length + hidden length), >= 1
ACC_W, 40, accumulator width, >= 2*XLEN + clog2(VEC_LEN) + 1

Ports:
clock  in  1  single clock, rising-edge
reset  in  1  asynchronous active-high reset
start  in  1  begin new dot product; sampled only in IDLE
b_i, b_c, b_f, b_o  in  XLEN each  gate biases (Q.FRAC), sampled on accepted start
in_valid  in  1  vector beat valid
in_ready  out  1  block accepts beat
x_data  in  XLEN  vector element
w_i, w_c, w_f, w_o  in  XLEN each  weights paired with x_data
gate_i, gate_c, gate_f, gate_o  out  XLEN each  rounded, saturated pre-activations (Q.FRAC)
out_valid  out  1  gate outputs valid
out_ready  in  1  downstream consumes outputs
status_out  out  2  0 IDLE, 1 ACCUM, 2 ROUND, 3 HOLD

Behaviour:
- Reset (asynchronous, active-high) forces the following, immediately and independent of the clock:
  - state goes to IDLE; accumulators and beat counter clear to 0
  - gate_* = 0, out_valid = 0, in_ready = 0, status_out = 0
- Reset mid-operation aborts the dot product; no partial result is ever emitted.
- IDLE:
  - in_ready = 0.
  - If start = 1: acc_g <= sign_extend(b_g) << FRAC for each gate g; counter <= 0; go to ACCUM.
  - start outside IDLE is ignored.
- ACCUM:
  - in_ready = 1. A beat is accepted when in_valid & in_ready.
  - Per accepted beat: acc_g <= acc_g + sext(w_g * x_data), using a full 2*XLEN signed product; counter increments.
  - The accepted beat with counter == VEC_LEN-1 goes to ROUND.
  - in_valid = 0 cycles stall accumulation with no state change.
- ROUND (exactly one cycle, in_ready = 0). For each gate:
  - r = (acc_g + (1 << (FRAC-1))) >>> FRAC (round half up, arithmetic shift)
  - saturate r to [-2^(XLEN-1), 2^(XLEN-1)-1]
  - register r into gate_g; out_valid <= 1; go to HOLD.
- HOLD:
  - out_valid = 1; gate_* are stable until the handshake completes.
  - On out_ready = 1: out_valid <= 0 at that edge and state goes to IDLE.
  - start in the same cycle as the HOLD handshake is ignored; it is accepted at the earliest one cycle later in IDLE.
- gate_* retain their last value after the handshake; they are only rewritten in ROUND.
- Latency: out_valid rises at the edge after the edge that accepts the last beat. Minimum start-to-out_valid = VEC_LEN + 2 cycles.
- Accumulator never wraps, given the ACC_W constraint; saturation occurs only at the XLEN output.
- status_out is registered state encoding. The downstream PE_STATE FIFO delays it in step with the data.

Test Plan:
1. Reset mid-ACCUM (VEC_LEN=4, 2 beats accepted), assert reset asynchronously -> outputs 0 and status_out=0 before the next clock edge; a new start then produces a result with no contribution from the aborted beats.
2. VEC_LEN=4, all biases 0, x=0x0100 (1.0), w_i=0x0100, w_c=0xFF00 (-1.0), w_f=0x0080 (0.5), w_o=0 on 4 back-to-back beats -> gate_i=0x0400, gate_c=0xFC00, gate_f=0x0200, gate_o=0x0000; out_valid one cycle after the 4th accepted beat; status sequence 1,1,1,1,2,3.
3. Bias plus rounding: b_i=0x0010, one beat x=0x0001, w_i=0x0080 (product 0x80 in Q16) -> gate_i = 0x0010 + round(0x80/256) = 0x0011; x=0x0001, w_i=0x007F -> 0x0010.
4. Saturation, VEC_LEN=4, x=0x7FFF, w_i=0x7FFF, w_c=0x8000 on all beats -> gate_i=0x7FFF, gate_c=0x8000.
5. Handshake: in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats accumulated and the result matches the no-gap case. out_ready held 0 for 5 cycles -> gate_* and out_valid stable; start pulsed during HOLD is ignored.
6. Back-to-back: out_ready=1 and start=1 in the same HOLD cycle -> start ignored. Start in the next IDLE cycle is accepted, and the second result uses the new biases.
